pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer for a simple fetch/execute core.
//
// Walks a four-state machine IDLE -> FETCH -> EXEC -> (FETCH | HALT). In FETCH
// it requests the instruction at pc and waits for the memory's ack. In EXEC it
// waits for the datapath's ex_done pulse, then retires the instruction. The next
// pc is either pc+4 or, for a taken branch, pc plus the 7-bit immediate scaled
// by 2. Execution stops on a halt instruction or when MAX_INSN instructions have
// been retired. From HALT, start restarts execution at RESET_PC.
//
// Optional feature (compile-time macro PC_SEQ_MISALIGN_TRAP_EN):
//   defined   - a taken branch whose target is not 4-byte aligned halts with
//               fault=1, leaving pc on the branch instruction.
//   undefined - misaligned targets are loaded as-is; fault is tied low.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  begin execution at RESET_PC (honoured in IDLE and HALT)
//   fetch_req  out  1  fetch request, high throughout FETCH
//   fetch_ack  in   1  instruction memory accepted the fetch
//   pc         out  8  program counter / fetch address
//   ex_done    in   1  datapath finished executing the current instruction
//   branch     in   1  current instruction is a conditional branch
//   zero_flag  in   1  ALU zero result of the current instruction
//   imm        in  64  signed immediate of the current instruction
//   halt_insn  in   1  current instruction is a halt
//   done       out  1  sequencer is in HALT
//   timeout    out  1  halt was caused by reaching MAX_INSN
//   fault      out  1  halt was caused by a misaligned branch target
//   insn_count out 16  instructions retired since the last start (saturating)

module pc_sequencer #(
    parameter logic [7:0]  RESET_PC = 8'd0,
    parameter logic [15:0] MAX_INSN = 16'd1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               fetch_req,
    input  logic               fetch_ack,
    output logic [7:0]         pc,
    input  logic               ex_done,
    input  logic               branch,
    input  logic               zero_flag,
    input  logic signed [63:0] imm,
    input  logic               halt_insn,
    output logic               done,
    output logic               timeout,
    output logic               fault,
    output logic [15:0]        insn_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_count;
    logic        r_done;
    logic        r_timeout;

    logic              w_taken;
    logic signed [7:0] w_offset;
    logic [7:0]        w_target;
    logic [7:0]        w_next_pc;
    logic [15:0]       w_count_inc;
    logic              w_hit_max;
    logic              w_imm_unused;

    // Only imm[6:0] contributes to the branch offset; the upper bits are
    // deliberately ignored.
    assign w_imm_unused = ^imm[63:7];

    assign w_taken     = branch & zero_flag;
    // Offset is imm[6:0] scaled by 2; as an 8-bit two's-complement value the
    // add below wraps modulo 256 for both directions.
    assign w_offset    = {imm[6:0], 1'b0};
    assign w_target    = r_pc + $unsigned(w_offset);
    assign w_next_pc   = w_taken ? w_target : (r_pc + 8'd4);
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : (r_count + 16'd1);
    assign w_hit_max   = (w_count_inc == MAX_INSN);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic r_fault;
    logic w_misalign;
    assign w_misalign = w_taken && (w_target[1:0] != 2'b00);
    assign fault      = r_fault;
`else
    assign fault      = 1'b0;
`endif

    // fetch_req follows the state directly so it is high in the very first
    // FETCH cycle, together with a stable pc.
    assign fetch_req  = (r_state == S_FETCH);
    assign pc         = r_pc;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign insn_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_count   <= 16'd0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            r_fault   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= RESET_PC;
                        r_count <= 16'd0;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ex_done) begin
                        r_count <= w_count_inc;
                        // A halt instruction wins over any branch; pc stays on it.
                        if (halt_insn) begin
                            r_state <= S_HALT;
                            r_done  <= 1'b1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                        end else if (w_misalign) begin
                            r_state <= S_HALT;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
`endif
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= S_FETCH;
                        end
                        // Reaching the retire limit stops execution instead of
                        // starting the next fetch.
                        if (w_hit_max) begin
                            r_state   <= S_HALT;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_pc      <= RESET_PC;
                        r_count   <= 16'd0;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                        r_fault   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
